btn_debounce_pulse: RTL

//  Conditions one raw mechanical push-button input into clean control strobes
//  for the 4-bit up-counter stage that follows it.

---
 rtl/btn_debounce_pulse.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//
// Turns one raw, bouncing push-button input into clean strobes for the
// 4-bit up-counter stage that follows it. The block synchronises the input,
// debounces it, and emits single-cycle press/release pulses. While the
// button is held it can also emit an auto-repeat pulse stream.
//
// Ports
//   clk          in   board clock; all logic runs on posedge
//   rst          in   asynchronous, active-low reset (release is re-timed to clk)
//   btn_in       in   raw button, asynchronous to clk, 1 = pressed
//   repeat_en    in   1 = auto-repeat enabled while held (sampled every cycle)
//   btn_level    out  debounced button level
//   btn_press    out  one-cycle pulse on accepted press
//   btn_release  out  one-cycle pulse on accepted release
//   btn_rpt      out  one-cycle auto-repeat pulse while held
//
// Parameters
//   DB_CYCLES      consecutive stable samples needed to accept a change (>=2)
//   REPEAT_DELAY   edges from the press edge to the first btn_rpt (>=1)
//   REPEAT_PERIOD  edges between later btn_rpt pulses (>=1)
//   CNT_W          counter width; must hold the largest of the three above
// ---------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int unsigned DB_CYCLES     = 2_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_rpt
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } state_e;

  // Terminal counts: a counter that already holds N-1 is on its N-th edge.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Reset re-timing: assertion stays asynchronous, release lands on a clock
  // edge so no flop sees reset deassert mid-cycle.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Two-flop synchroniser; sync_in is the only view of the button used below.
  // -------------------------------------------------------------------------
  logic [1:0] btn_sync_q;
  logic       sync_in;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      btn_sync_q <= 2'b00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_in};
    end
  end

  assign sync_in = btn_sync_q[1];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_period_q, rpt_period_d;  // 0: initial delay, 1: period
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rpt_q, rpt_d;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      rpt_cnt_q    <= '0;
      rpt_period_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      rpt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_period_q <= rpt_period_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      rpt_q        <= rpt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: debounce counting. db_cnt counts consecutive samples
  // that disagree with the current accepted level.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync_in) begin
          state_d  = ARM_PRESS;
          db_cnt_d = CNT_ONE;
        end
      end
      ARM_PRESS: begin
        if (!sync_in) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_in) begin
          state_d  = ARM_RELEASE;
          db_cnt_d = CNT_ONE;
        end
      end
      ARM_RELEASE: begin
        if (sync_in) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: pulses are decoded from the transition being taken this
  // edge and registered, so they appear in the cycle after that edge.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] rpt_last;

  always_comb begin
    press_d      = (state_q == ARM_PRESS)   && (state_d == HELD);
    release_d    = (state_q == ARM_RELEASE) && (state_d == IDLE);
    // The accepted level is 1 in both states that sit above a press.
    level_d      = (state_d == HELD) || (state_d == ARM_RELEASE);
    rpt_d        = 1'b0;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_period_d = rpt_period_q;
    rpt_last     = rpt_period_q ? PER_LAST : DLY_LAST;

    if (press_d) begin
      rpt_cnt_d    = '0;
      rpt_period_d = 1'b0;
    end else if ((state_q == HELD) && (state_d == HELD)) begin
      if (!repeat_en) begin
        // Held at zero so re-enabling starts the full initial delay again.
        rpt_cnt_d    = '0;
        rpt_period_d = 1'b0;
      end else if (rpt_cnt_q == rpt_last) begin
        rpt_d        = 1'b1;
        rpt_cnt_d    = '0;
        rpt_period_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
      end
    end
    // Any other case (release debounce, bounce back to HELD) keeps the
    // repeat counter frozen so a rejected release resumes the cadence.
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_rpt     = rpt_q;

endmodule
